// File: rtl/pin_motor_seq.sv
// -----------------------------------------------------------------------------
// pin_motor_seq
//   Sequencer directly upstream of pin_motor and the only driver of its 2-bit
//   motor_state input. Each accepted start runs one pin cycle:
//   PULL (BACKWARD) -> HOLD (STOP) -> RELEASE (FORWARD) -> DONE -> IDLE.
//   The HOLD state is also the dead time between the two direction reversals,
//   so FORWARD and BACKWARD are never driven on adjacent cycles.
//   An abort forces STOP for DEAD_CYCLES clocks before the sequencer returns
//   to IDLE.
//
//   Optional feature macro: PIN_MOTOR_LIMIT_EN
//     When defined, a limit_sw port is added. It is synchronised by two flops.
//     A high synchronised limit ends PULL early and blocks start in IDLE.
//
// Ports
//   clk          in   1  100 MHz system clock
//   rst          in   1  asynchronous, active-high reset
//   start        in   1  one-cycle start request, honoured only in IDLE
//   abort        in   1  terminates an active PULL/HOLD/RELEASE
//   limit_sw     in   1  pin end-stop, asynchronous (PIN_MOTOR_LIMIT_EN only)
//   motor_state  out  2  00 STOP, 01 FORWARD, 10 BACKWARD (11 never driven)
//   busy         out  1  high in every state except IDLE
//   done         out  1  one-cycle pulse on normal completion
//   aborted      out  1  one-cycle pulse on the first ABORT cycle
// -----------------------------------------------------------------------------
module pin_motor_seq #(
  parameter logic [31:0] PULL_CYCLES    = 32'd30_000_000,
  parameter logic [31:0] HOLD_CYCLES    = 32'd20_000_000,
  parameter logic [31:0] RELEASE_CYCLES = 32'd25_000_000,
  parameter logic [31:0] DEAD_CYCLES    = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef PIN_MOTOR_LIMIT_EN
  input  logic       limit_sw,
`endif
  output logic [1:0] motor_state,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULL    = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  localparam logic [1:0] MS_STOP     = 2'b00;
  localparam logic [1:0] MS_FORWARD  = 2'b01;
  localparam logic [1:0] MS_BACKWARD = 2'b10;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_motor_state;
  logic        r_busy;
  logic        r_done;
  logic        r_aborted;
  state_t      w_next;
  logic        w_limit;

`ifdef PIN_MOTOR_LIMIT_EN
  logic r_lim_s1;
  logic r_lim_s2;

  // Two-flop synchroniser for the asynchronous end-stop switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lim_s1 <= 1'b0;
      r_lim_s2 <= 1'b0;
    end else begin
      r_lim_s1 <= limit_sw;
      r_lim_s2 <= r_lim_s1;
    end
  end

  assign w_limit = r_lim_s2;
`else
  assign w_limit = 1'b0;
`endif

  // Next-state decode. Abort outranks every other condition, including the
  // counter terminal count and the limit switch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort && !w_limit) w_next = S_PULL;
      end
      S_PULL: begin
        if (abort)                                 w_next = S_ABORT;
        else if (w_limit)                          w_next = S_HOLD;
        else if (r_cnt == PULL_CYCLES - 32'd1)     w_next = S_HOLD;
      end
      S_HOLD: begin
        if (abort)                                 w_next = S_ABORT;
        else if (r_cnt == HOLD_CYCLES - 32'd1)     w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (abort)                                 w_next = S_ABORT;
        else if (r_cnt == RELEASE_CYCLES - 32'd1)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      S_ABORT: begin
        if (r_cnt == DEAD_CYCLES - 32'd1)          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counter and outputs are all loaded from w_next on the same edge,
  // so the outputs describe the current state with no extra latency.
  // The counter restarts on every state change and is held at zero in IDLE,
  // so it never exceeds the largest terminal count and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      r_motor_state <= MS_STOP;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (w_next == S_IDLE)) r_cnt <= 32'd0;
      else                                           r_cnt <= r_cnt + 32'd1;
      case (w_next)
        S_PULL:    r_motor_state <= MS_BACKWARD;
        S_RELEASE: r_motor_state <= MS_FORWARD;
        default:   r_motor_state <= MS_STOP;
      endcase
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_aborted <= (w_next == S_ABORT) && (r_state != S_ABORT);
    end
  end

  assign motor_state = r_motor_state;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_pin_motor_seq.sv
// -----------------------------------------------------------------------------
// tb_pin_motor_seq
//   Directed bench for pin_motor_seq with PULL=8, HOLD=4, RELEASE=6, DEAD=3.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pin_motor_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       limit_sw;
  logic [1:0] motor_state;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_cmp = 0;
  int n_err = 0;

  pin_motor_seq #(
    .PULL_CYCLES   (32'd8),
    .HOLD_CYCLES   (32'd4),
    .RELEASE_CYCLES(32'd6),
    .DEAD_CYCLES   (32'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
`ifdef PIN_MOTOR_LIMIT_EN
    .limit_sw   (limit_sw),
`endif
    .motor_state(motor_state),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs in one call.
  task automatic chk_all(input string tag, input logic [1:0] ms, input logic b,
                         input logic d, input logic a);
    chk({tag, ".motor_state"}, {30'd0, motor_state}, {30'd0, ms});
    chk({tag, ".busy"},        {31'd0, busy},        {31'd0, b});
    chk({tag, ".done"},        {31'd0, done},        {31'd0, d});
    chk({tag, ".aborted"},     {31'd0, aborted},     {31'd0, a});
  endtask

  initial begin
    logic [1:0] exp_ms;

    rst = 1'b1; start = 1'b0; abort = 1'b0; limit_sw = 1'b0;

    // Reset and idle
    #2;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk_all("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Full cycle; a start pulse during HOLD clock 2 must not disturb it
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      if (i <= 8)       exp_ms = 2'b10;
      else if (i <= 12) exp_ms = 2'b00;
      else if (i <= 18) exp_ms = 2'b01;
      else              exp_ms = 2'b00;
      chk_all($sformatf("full.c%0d", i), exp_ms, 1'b1, (i == 19), 1'b0);
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk_all("full.end", 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort in RELEASE clock 3, abort held high and start tried during ABORT
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    chk_all("abrt.rel3", 2'b01, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    chk_all("abrt.a1", 2'b00, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("abrt.a2", 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("abrt.a3", 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("abrt.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    tick();
    chk_all("abrt.idle2", 2'b00, 1'b0, 1'b0, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_all("st_ab", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("st_ab2", 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort during DONE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 19; i++) tick();
    chk_all("dn.done", 2'b00, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("dn.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort in PULL clock 1 (first possible cycle)
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("pab.a1", 2'b00, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk_all("pab.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-PULL, no clock edge in between
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_all("rst.pull", 2'b10, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_all("rst.async", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("rst.idle", 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef PIN_MOTOR_LIMIT_EN
    // limit_sw raised during PULL clock 2: HOLD entered 3 clocks later
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    limit_sw = 1'b1;
    tick();
    chk_all("lim.c3", 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("lim.c4", 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("lim.hold", 2'b00, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick(); tick();
    chk_all("lim.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    // limit_sw held high: start ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("lim.blk", 2'b00, 1'b0, 1'b0, 1'b0);
    limit_sw = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
